// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM states, default width.
package alu_sequencer_pkg;

  localparam int W_DEF = 5;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MUL  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic is_mul(input logic [1:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/result bundle between the switch/button front end and the sequencer.
interface alu_sequencer_if #(
  parameter int W = 5
);
  logic             start;
  logic [1:0]       op;
  logic [2*W-1:0]   operands;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   result;
  logic             sign;
  logic             overflow;

  modport master (
    output start, op, operands,
    input  busy, done, result, sign, overflow
  );

  modport slave (
    input  start, op, operands,
    output busy, done, result, sign, overflow
  );
endinterface

// File: rtl/alu_sequencer_mul_shift_add.sv
// Unsigned W x W shift-add multiplier over one W+1-bit adder; one step per
// asserted step_i, done_o once W steps have been taken since load_i.
module mul_shift_add #(
  parameter int W = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [W-1:0]   mcand_i,
  input  logic [W-1:0]   mplier_i,
  output logic [2*W-1:0] product_o,
  output logic           done_o
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  mplr_q, mplr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  addend;
  logic [W:0]    sum;
  logic          last;

  assign last = (cnt_q == CW'(W));

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    addend  = mplr_q[0] ? mcand_q : '0;
    sum     = {1'b0, acc_q} + {1'b0, addend};
    if (load_i) begin
      mcand_d = mcand_i;
      acc_d   = '0;
      mplr_d  = mplier_i;
      cnt_d   = '0;
    end else if (step_i && !last) begin
      // Carry out of the adder shifts into the accumulator MSB, its LSB into the multiplier.
      acc_d  = sum[W:1];
      mplr_d = {sum[0], mplr_q[W-1:1]};
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign product_o = {acc_q, mplr_q};
  assign done_o    = last;

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer for the signed W-bit lab ALU: single-cycle add/sub/neg, shift-add multiply,
// held 2W-bit signed result with sign/overflow and a busy/done handshake.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus
);

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   left_q, left_d;
  logic [W-1:0]   right_q, right_d;
  logic           neg_q, neg_d;
  logic [2*W-1:0] result_q, result_d;
  logic           ovf_q, ovf_d;

  logic           mul_load;
  logic           mul_step;
  logic           mul_done;
  logic [2*W-1:0] mul_prod;
  logic [2*W-1:0] mul_res;
  logic [W:0]     mul_top;
  logic [W:0]     sum;
  logic [W-1:0]   in_left;
  logic [W-1:0]   in_right;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? (~x + 1'b1) : x;
  endfunction

  assign in_left  = bus.operands[2*W-1:W];
  assign in_right = bus.operands[W-1:0];

  mul_shift_add #(.W(W)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .mcand_i   (mag(in_left)),
    .mplier_i  (mag(in_right)),
    .product_o (mul_prod),
    .done_o    (mul_done)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    left_d   = left_q;
    right_d  = right_q;
    neg_d    = neg_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    sum      = '0;
    mul_res  = '0;
    mul_top  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          left_d  = in_left;
          right_d = in_right;
          ovf_d   = 1'b0;
          if (is_mul(bus.op)) begin
            mul_load = 1'b1;
            neg_d    = in_left[W-1] ^ in_right[W-1];
            state_d  = ST_MUL;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        case (op_q)
          OP_ADD:  sum = {left_q[W-1], left_q} + {right_q[W-1], right_q};
          OP_SUB:  sum = {left_q[W-1], left_q} - {right_q[W-1], right_q};
          default: sum = '0 - {left_q[W-1], left_q};
        endcase
        result_d = {{(W-1){sum[W]}}, sum};
        ovf_d    = sum[W] ^ sum[W-1];
        state_d  = ST_DONE;
      end

      ST_MUL: begin
        if (mul_done) begin
          mul_res  = neg_q ? (-mul_prod) : mul_prod;
          // Fits in W signed bits only if the top W+1 bits are all copies of the sign.
          mul_top  = mul_res[2*W-1:W-1];
          result_d = mul_res;
          ovf_d    = !((&mul_top) || !(|mul_top));
          state_d  = ST_DONE;
        end else begin
          mul_step = 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      left_q   <= '0;
      right_q  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      left_q   <= left_d;
      right_q  <= right_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.result   = result_q;
  assign bus.sign     = result_q[2*W-1];
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed checks of alu_sequencer against an integer-arithmetic model.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int W = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_sequencer_if #(.W(W)) bus ();

  alu_sequencer #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic int model(input logic [1:0] op, input int l, input int r);
    case (op)
      OP_ADD:  return l + r;
      OP_SUB:  return l - r;
      OP_MUL:  return l * r;
      default: return -l;
    endcase
  endfunction

  function automatic logic [2*W-1:0] pack(input int l, input int r);
    logic [W-1:0] lv;
    logic [W-1:0] rv;
    lv = l[W-1:0];
    rv = r[W-1:0];
    return {lv, rv};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation from IDLE and checks latency, outputs and the return to IDLE.
  task automatic run_op(input logic [1:0] op, input int l, input int r);
    int             exp_val;
    logic [2*W-1:0] exp_res;
    logic           exp_ovf;
    int             exp_lat;
    int             lat;
    exp_val = model(op, l, r);
    exp_res = exp_val[2*W-1:0];
    exp_ovf = (exp_val < -16) || (exp_val > 15);
    exp_lat = (op == OP_MUL) ? W + 2 : 2;
    bus.start    = 1'b1;
    bus.op       = op;
    bus.operands = pack(l, r);
    tick();
    bus.start    = 1'b0;
    bus.op       = 2'($urandom);
    bus.operands = 10'($urandom);
    lat = 1;
    checks++;
    if (bus.busy !== 1'b1)
      $display("FAIL busy_after_start op=%0d got %b want 1", op, bus.busy);
    if (bus.busy !== 1'b1) errors++;
    while (bus.done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency op=%0d l=%0d r=%0d got %0d want %0d", op, l, r, lat, exp_lat);
    end
    checks++;
    if (bus.result !== exp_res || bus.sign !== exp_res[2*W-1] || bus.overflow !== exp_ovf) begin
      errors++;
      $display("FAIL result op=%0d l=%0d r=%0d got %h/s%b/o%b want %h/s%b/o%b", op, l, r,
               bus.result, bus.sign, bus.overflow, exp_res, exp_res[2*W-1], exp_ovf);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== exp_res) begin
      errors++;
      $display("FAIL after_done busy=%b done=%b result=%h want 0/0/%h",
               bus.busy, bus.done, bus.result, exp_res);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = OP_ADD;
    bus.operands = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({bus.busy, bus.done, bus.result, bus.sign, bus.overflow} !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d busy=%b done=%b result=%h sign=%b ovf=%b want all 0",
                 i, bus.busy, bus.done, bus.result, bus.sign, bus.overflow);
      end
    end
  endtask

  task automatic test_directed();
    run_op(OP_ADD, 7, 9);
    run_op(OP_SUB, -16, 1);
    run_op(OP_NEG, -16, 0);
    run_op(OP_MUL, -16, -16);
    run_op(OP_MUL, 3, -5);
    run_op(OP_MUL, 15, -16);
    run_op(OP_NEG, 0, 7);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), int'($urandom_range(31)) - 16, int'($urandom_range(31)) - 16);
      if ($urandom_range(1) == 1) tick();
    end
  endtask

  task automatic test_start_during_mul();
    int dones = 0;
    logic [2*W-1:0] exp_res;
    int exp_val;
    exp_val = model(OP_MUL, -7, 6);
    exp_res = exp_val[2*W-1:0];
    bus.start = 1'b1;
    bus.op = OP_MUL;
    bus.operands = pack(-7, 6);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2 || i == 3) begin
        bus.start = 1'b1;
        bus.op = OP_ADD;
        bus.operands = pack(11, 2);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        dones++;
        checks++;
        if (bus.result !== exp_res) begin
          errors++;
          $display("FAIL start_in_mul result got %h want %h", bus.result, exp_res);
        end
      end
      tick();
    end
    bus.start = 1'b0;
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL start_in_mul done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid_mul();
    run_op(OP_ADD, 5, 6);
    bus.start = 1'b1;
    bus.op = OP_MUL;
    bus.operands = pack(5, 5);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
      errors++;
      $display("FAIL reset_mid_mul busy=%b done=%b result=%h want 0/0/000",
               bus.busy, bus.done, bus.result);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.done !== 1'b0 || bus.result !== '0) begin
        errors++;
        $display("FAIL reset_mid_mul_quiet cyc=%0d done=%b result=%h want 0/000", i, bus.done, bus.result);
      end
      tick();
    end
    // Reset wins over a simultaneous start.
    reset = 1'b1;
    bus.start = 1'b1;
    bus.op = OP_ADD;
    bus.operands = pack(1, 1);
    tick();
    reset = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_same_cycle busy got %b want 0", bus.busy);
    end
    tick();
    run_op(OP_MUL, 5, 5);
  endtask

  task automatic test_back_to_back(input logic [1:0] op, input int l, input int r, input int period);
    int last = -1;
    int nd = 0;
    int exp_val;
    logic [2*W-1:0] exp_res;
    exp_val = model(op, l, r);
    exp_res = exp_val[2*W-1:0];
    bus.start = 1'b1;
    bus.op = op;
    bus.operands = pack(l, r);
    for (int c = 0; c < 6 * period; c++) begin
      tick();
      if (bus.done === 1'b1) begin
        checks++;
        if (bus.result !== exp_res || (last >= 0 && c - last != period)) begin
          errors++;
          $display("FAIL back_to_back op=%0d cyc=%0d result=%h want %h spacing=%0d want %0d",
                   op, c, bus.result, exp_res, c - last, period);
        end
        last = c;
        nd++;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (nd < 5) begin
      errors++;
      $display("FAIL back_to_back_count op=%0d got %0d want >=5", op, nd);
    end
    for (int i = 0; i < 20 && bus.busy !== 1'b0; i++) tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_drain busy got %b want 0", bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_during_mul();
    test_reset_mid_mul();
    test_back_to_back(OP_ADD, 3, 4, 3);
    test_back_to_back(OP_MUL, -9, 7, W + 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
